// File: rtl/fu_sched_pkg.sv
// Shared types, default latencies and the FU rotation helper for fu_issue_scheduler.
package fu_sched_pkg;

  localparam int NUM_FU      = 3;
  localparam int DEF_ALU_LAT = 1;
  localparam int DEF_LS_LAT  = 3;

  typedef logic [1:0] fu_id_t;

  function automatic fu_id_t fu_succ(input fu_id_t cur);
    return (cur == 2'd2) ? 2'd0 : cur + 2'd1;
  endfunction

  // Prefer the next FU, then the one after, then the current one; if none is ready, the next.
  function automatic fu_id_t next_fu(input fu_id_t cur, input logic [NUM_FU-1:0] ready);
    fu_id_t n1;
    fu_id_t n2;
    n1 = fu_succ(cur);
    n2 = fu_succ(n1);
    if (ready[n1])       return n1;
    else if (ready[n2])  return n2;
    else if (ready[cur]) return cur;
    else                 return n1;
  endfunction

endpackage

// File: rtl/fu_busy_timer.sv
// Per-FU occupancy countdown: raises done one cycle per op, LAT cycles after the load edge.
module fu_busy_timer #(
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W:0]   lat,
  input  logic             is_ls,
  output logic             busy,
  output logic             done,
  output logic             holds_ls
);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W:0]   lat_m1;
  logic             done_q;
  logic             ls_q;

  assign lat_m1 = lat - 1'b1;

  // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt    <= '0;
      done_q <= 1'b0;
      ls_q   <= 1'b0;
    end else if (load) begin
      cnt    <= lat_m1[CNT_W-1:0];
      done_q <= (lat == (CNT_W+1)'(1));
      ls_q   <= is_ls;
    end else begin
      if (cnt != '0) cnt <= cnt - 1'b1;
      done_q <= (cnt == CNT_W'(1));
    end
  end

  assign busy     = (cnt != '0);
  assign done     = done_q;
  assign holds_ls = ls_q && busy;

endmodule

// File: rtl/fu_issue_scheduler.sv
// FU issue scheduler: FU assignment at dispatch, per-FU occupancy, single LS port, error flag.
// Optional per-FU accepted-issue statistics are built when FU_SCHED_STATS_EN is defined.
module fu_issue_scheduler
  import fu_sched_pkg::*;
#(
  parameter int ALU_LAT = DEF_ALU_LAT,
  parameter int LS_LAT  = DEF_LS_LAT,
  parameter int CNT_W   = 3,
  parameter int STAT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              dispatch_valid,
  input  logic              issue_FU1_valid,
  input  logic              issue_FU2_valid,
  input  logic              issue_FU3_valid,
  input  logic              issue_0_is_LS,
  input  logic              issue_1_is_LS,
  input  logic              issue_2_is_LS,
  output logic [1:0]        FU_num,
  output logic              FU1_ready,
  output logic              FU2_ready,
  output logic              FU3_ready,
  output logic              ls_port_free,
  output logic [2:0]        fu_done,
  output logic              issue_err,
  output logic [STAT_W-1:0] stat_fu0,
  output logic [STAT_W-1:0] stat_fu1,
  output logic [STAT_W-1:0] stat_fu2
);

  localparam logic [CNT_W:0] ALU_L = (CNT_W+1)'(ALU_LAT);
  localparam logic [CNT_W:0] LS_L  = (CNT_W+1)'(LS_LAT);

  logic [NUM_FU-1:0] valid, is_ls, busy, done, holds_ls, ready, accept, reject;
  logic              ls_inflight;
  logic              ls_taken;
  fu_id_t            fu_num_q;

  assign valid = {issue_FU3_valid, issue_FU2_valid, issue_FU1_valid};
  assign is_ls = {issue_2_is_LS, issue_1_is_LS, issue_0_is_LS};

  for (genvar i = 0; i < NUM_FU; i++) begin : g_fu
    fu_busy_timer #(.CNT_W(CNT_W)) u_timer (
      .clk      (clk),
      .reset    (reset),
      .load     (accept[i]),
      .lat      (is_ls[i] ? LS_L : ALU_L),
      .is_ls    (is_ls[i]),
      .busy     (busy[i]),
      .done     (done[i]),
      .holds_ls (holds_ls[i])
    );
  end

  // The holder drops holds_ls in its completion cycle, so the port frees exactly as done fires.
  assign ls_inflight = |holds_ls;
  assign ready       = ~busy & {NUM_FU{!ls_inflight}};

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    accept   = '0;
    ls_taken = 1'b0;
    for (int i = 0; i < NUM_FU; i++) begin
      if (valid[i] && ready[i] && !(is_ls[i] && ls_taken)) begin
        accept[i] = 1'b1;
        if (is_ls[i]) ls_taken = 1'b1;
      end
    end
  end

  assign reject = valid & ~accept;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fu_num_q  <= 2'd2;
      issue_err <= 1'b0;
    end else begin
      if (dispatch_valid) fu_num_q <= next_fu(fu_num_q, ready);
      if (|reject)        issue_err <= 1'b1;
    end
  end

  assign FU_num       = fu_num_q;
  assign FU1_ready    = ready[0];
  assign FU2_ready    = ready[1];
  assign FU3_ready    = ready[2];
  assign ls_port_free = !ls_inflight;
  assign fu_done      = done;

`ifdef FU_SCHED_STATS_EN
  logic [STAT_W-1:0] stat_q [NUM_FU];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_FU; i++) stat_q[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_FU; i++)
        if (accept[i] && (stat_q[i] != '1)) stat_q[i] <= stat_q[i] + 1'b1;
    end
  end

  assign stat_fu0 = stat_q[0];
  assign stat_fu1 = stat_q[1];
  assign stat_fu2 = stat_q[2];
`else
  assign stat_fu0 = '0;
  assign stat_fu1 = '0;
  assign stat_fu2 = '0;
`endif

endmodule

// File: tb/tb_fu_issue_scheduler.sv
// Self-checking bench for fu_issue_scheduler: directed steps then random traffic vs a time-based model.
// Statistic expectations follow FU_SCHED_STATS_EN the same way the design does.
module tb_fu_issue_scheduler;

  localparam int ALU_LAT = 1;
  localparam int LS_LAT  = 3;
  localparam int CNT_W   = 3;
  localparam int STAT_W  = 16;

  logic              clk;
  logic              reset;
  logic              dispatch_valid;
  logic              issue_FU1_valid, issue_FU2_valid, issue_FU3_valid;
  logic              issue_0_is_LS, issue_1_is_LS, issue_2_is_LS;
  logic [1:0]        FU_num;
  logic              FU1_ready, FU2_ready, FU3_ready;
  logic              ls_port_free;
  logic [2:0]        fu_done;
  logic              issue_err;
  logic [STAT_W-1:0] stat_fu0, stat_fu1, stat_fu2;

  fu_issue_scheduler #(
    .ALU_LAT(ALU_LAT), .LS_LAT(LS_LAT), .CNT_W(CNT_W), .STAT_W(STAT_W)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .dispatch_valid  (dispatch_valid),
    .issue_FU1_valid (issue_FU1_valid),
    .issue_FU2_valid (issue_FU2_valid),
    .issue_FU3_valid (issue_FU3_valid),
    .issue_0_is_LS   (issue_0_is_LS),
    .issue_1_is_LS   (issue_1_is_LS),
    .issue_2_is_LS   (issue_2_is_LS),
    .FU_num          (FU_num),
    .FU1_ready       (FU1_ready),
    .FU2_ready       (FU2_ready),
    .FU3_ready       (FU3_ready),
    .ls_port_free    (ls_port_free),
    .fu_done         (fu_done),
    .issue_err       (issue_err),
    .stat_fu0        (stat_fu0),
    .stat_fu1        (stat_fu1),
    .stat_fu2        (stat_fu2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Model: each FU is free from a given cycle, completes at a given cycle; the LS port is
  // occupied until a given cycle. Cycle numbers count from the last reset release.
  int cyc;
  int free_at [3];
  int done_at [3];
  int ls_until;
  int m_fu;
  bit m_err;
  int m_stat [3];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      free_at[i] = 0;
      done_at[i] = -1;
      m_stat[i]  = 0;
    end
    ls_until = 0;
    m_fu     = 2;
    m_err    = 1'b0;
    cyc      = 0;
  endtask

  function automatic bit m_ready(input int i);
    return (cyc >= free_at[i]) && (cyc >= ls_until);
  endfunction

  function automatic int pick_fu(input int cur, input bit [2:0] rdy);
    for (int k = 1; k <= 3; k++)
      if (rdy[(cur + k) % 3]) return (cur + k) % 3;
    return (cur + 1) % 3;
  endfunction

  function automatic int exp_stat(input int i);
`ifdef FU_SCHED_STATS_EN
    return m_stat[i];
`else
    return 0 * i;
`endif
  endfunction

  task automatic check_outputs(input string where);
    logic [2:0] d;
    for (int i = 0; i < 3; i++) d[i] = (done_at[i] == cyc);
    check($sformatf("%s c%0d fu0_ready", where, cyc), 32'(FU1_ready), 32'(m_ready(0)));
    check($sformatf("%s c%0d fu1_ready", where, cyc), 32'(FU2_ready), 32'(m_ready(1)));
    check($sformatf("%s c%0d fu2_ready", where, cyc), 32'(FU3_ready), 32'(m_ready(2)));
    check($sformatf("%s c%0d ls_port_free", where, cyc), 32'(ls_port_free), 32'(cyc >= ls_until));
    check($sformatf("%s c%0d fu_done", where, cyc), 32'(fu_done), 32'(d));
    check($sformatf("%s c%0d issue_err", where, cyc), 32'(issue_err), 32'(m_err));
    check($sformatf("%s c%0d FU_num", where, cyc), 32'(FU_num), 32'(m_fu));
    check($sformatf("%s c%0d stat0", where, cyc), 32'(stat_fu0), 32'(exp_stat(0)));
    check($sformatf("%s c%0d stat1", where, cyc), 32'(stat_fu1), 32'(exp_stat(1)));
    check($sformatf("%s c%0d stat2", where, cyc), 32'(stat_fu2), 32'(exp_stat(2)));
  endtask

  // Called at a falling edge: drive one cycle of inputs, check, advance model and clock.
  task automatic step(input string where, input bit disp, input bit [2:0] v, input bit [2:0] ls);
    bit [2:0] rdy;
    bit       ls_taken;
    int       lat;
    dispatch_valid  = disp;
    issue_FU1_valid = v[0];
    issue_FU2_valid = v[1];
    issue_FU3_valid = v[2];
    issue_0_is_LS   = ls[0];
    issue_1_is_LS   = ls[1];
    issue_2_is_LS   = ls[2];
    check_outputs(where);
    for (int i = 0; i < 3; i++) rdy[i] = m_ready(i);
    ls_taken = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (v[i]) begin
        if (rdy[i] && !(ls[i] && ls_taken)) begin
          lat        = ls[i] ? LS_LAT : ALU_LAT;
          free_at[i] = cyc + lat;
          done_at[i] = cyc + lat;
          if (ls[i]) begin
            ls_until = cyc + lat;
            ls_taken = 1'b1;
          end
          if (m_stat[i] < (2 ** STAT_W) - 1) m_stat[i]++;
        end else begin
          m_err = 1'b1;
        end
      end
    end
    if (disp) m_fu = pick_fu(m_fu, rdy);
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  task automatic idle(input string where, input int n);
    for (int k = 0; k < n; k++) step(where, 1'b0, 3'b000, 3'b000);
  endtask

  // Reset asserted at a falling edge, held across one rising edge, released at the next fall.
  task automatic do_reset(input string where);
    dispatch_valid  = 1'b0;
    issue_FU1_valid = 1'b0;
    issue_FU2_valid = 1'b0;
    issue_FU3_valid = 1'b0;
    issue_0_is_LS   = 1'b0;
    issue_1_is_LS   = 1'b0;
    issue_2_is_LS   = 1'b0;
    reset = 1'b1;
    #1;
    model_reset();
    check_outputs({where, "_in_reset"});
    @(posedge clk);
    @(negedge clk);
    check_outputs({where, "_held"});
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    @(negedge clk);
    do_reset("por");

    // Dispatch with everything idle walks 0, 1, 2.
    step("disp", 1'b1, 3'b000, 3'b000);
    step("disp", 1'b1, 3'b000, 3'b000);
    step("disp", 1'b1, 3'b000, 3'b000);
    check("disp_third_fu", 32'(FU_num), 32'd2);

    // Back-to-back ALU on FU0.
    for (int k = 0; k < 4; k++) step("alu_b2b", 1'b0, 3'b001, 3'b000);
    idle("alu_tail", 2);

    // LS on FU1 with a dispatch while the port is busy, then an issue that lands on done.
    step("ls_fu1", 1'b0, 3'b010, 3'b010);
    step("ls_busy", 1'b1, 3'b000, 3'b000);
    step("ls_busy", 1'b1, 3'b000, 3'b000);
    step("ls_done_reissue", 1'b1, 3'b010, 3'b000);
    idle("ls_tail", 2);

    // Issue to a busy FU, then simultaneous LS on FU0 and FU2 after a clean reset.
    step("err_ls", 1'b0, 3'b010, 3'b010);
    step("err_busy", 1'b0, 3'b010, 3'b000);
    idle("err_tail", 3);
    do_reset("rst_err");
    step("dual_ls", 1'b0, 3'b101, 3'b101);
    idle("dual_tail", 4);

    // Reset two cycles into an LS: no done pulse afterwards.
    do_reset("rst_pre");
    step("mid_ls", 1'b0, 3'b100, 3'b100);
    idle("mid_ls", 2);
    do_reset("rst_mid");
    check("mid_rst_fu_num", 32'(FU_num), 32'd2);
    idle("post_rst", 3);

    // Random traffic, biased toward issuing to FUs the model believes ready.
    for (int blk = 0; blk < 4; blk++) begin
      do_reset("rnd_rst");
      for (int n = 0; n < 100; n++) begin
        bit [2:0] v;
        bit [2:0] ls;
        for (int i = 0; i < 3; i++) begin
          v[i]  = (m_ready(i) && ($urandom_range(0, 2) == 0)) || ($urandom_range(0, 15) == 0);
          ls[i] = ($urandom_range(0, 2) == 0);
        end
        step("rnd", 1'($urandom_range(0, 1)), v, ls);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
